lc3_decode: RTL and testbench
=============================

LC3_DECODE -- requirements
Module: lc3_decode

Interface
REQ-001 SHALL have port: clock  input  1  single design clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: enable_decode  input  1  capture strobe from pipeline control; 1 = decode and register the current instruction this cycle.
REQ-004 SHALL have port: dout  input  16  instruction word from instruction memory (fetch stage).
REQ-005 SHALL have port: npc_in  input  16  PC+1 from the fetch stage.
REQ-006 SHALL have port: IR  output  16  registered instruction, feeds the execute stage.
REQ-007 SHALL have port: npc_out  output  16  registered npc_in, feeds execute npc_in.
REQ-008 SHALL have port: E_Control  output  6  execute control {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
REQ-009 SHALL have port: Mem_Control  output  1  1 = indirect memory access (LDI/STI).
REQ-010 SHALL have port: W_Control  output  2  writeback select: 0 = aluout, 1 = memout, 2 = pcout (3 unused).
REQ-011 SHALL have port: decode_valid  output  1  1 = outputs hold an instruction captured at the previous enabled edge.

Function
REQ-012 SHALL make all outputs registered; no combinational path from any input to any output.
REQ-013 SHALL, at a rising edge with enable_decode=1: IR<=dout, npc_out<=npc_in, controls<=decode(dout), decode_valid<=1; latency one cycle.
REQ-014 SHALL, at a rising edge with enable_decode=0: hold IR, npc_out, E_Control, Mem_Control and W_Control; decode_valid<=0.
REQ-015 SHALL decode opcode dout[15:12] as follows (fields not listed are 0):
 - ADD 0001: alu=00, op2select=~dout[5], W=0
 - AND 0101: alu=01, op2select=~dout[5], W=0
 - NOT 1001: alu=10, op2select=1, W=0
 - BR 0000: pcselect1=01, pcselect2=1, W=0
 - JMP 1100: pcselect1=11, pcselect2=0, W=0
 - LD 0010: pcselect1=01, pcselect2=1, W=1, Mem=0
 - LDR 0110: pcselect1=10, pcselect2=0, W=1, Mem=0
 - LDI 1010: pcselect1=01, pcselect2=1, W=1, Mem=1
 - LEA 1110: pcselect1=01, pcselect2=1, W=2, Mem=0
 - ST 0011: pcselect1=01, pcselect2=1, W=0, Mem=0
 - STR 0111: pcselect1=10, pcselect2=0, W=0, Mem=0
 - STI 1011: pcselect1=01, pcselect2=1, W=0, Mem=1
REQ-016 SHALL, for unsupported opcodes (0100 JSR, 1000 RTI, 1101, 1111 TRAP): register IR and npc_out normally, drive E_Control=0, Mem_Control=0, W_Control=0, decode_valid=1.
REQ-017 SHALL use op2select = 1 for the register operand (VSR2) and 0 for sign-extended imm5.
REQ-018 SHALL make the decode a pure function of dout; no dependence on previous instructions.
REQ-019 SHALL pass npc_in unmodified; no arithmetic on npc.

Reset
REQ-020 SHALL, while reset=0, immediately (asynchronously) force IR=0, npc_out=0, E_Control=0, Mem_Control=0, W_Control=0, decode_valid=0, regardless of clock or enable_decode.
REQ-021 SHALL, on reset deassertion, change no output until the first rising edge with enable_decode=1.
REQ-022 SHALL make reset assertion mid-stream discard the held instruction; no capture occurs on any edge while reset=0.

Verification
REQ-023 SHALL cover: dout=0x1283 (ADD R1,R2,R3), npc_in=0x3001, enable=1 -> next cycle IR=0x1283, npc_out=0x3001, E_Control=6'b000001, W=0, Mem=0, decode_valid=1.
REQ-024 SHALL cover: dout=0x12A5 (ADD imm) -> E_Control=6'b000000, W=0; then dout=0xA005 (LDI) -> E_Control=6'b000110, W=1, Mem=1.
REQ-025 SHALL cover: dout=0xE00A (LEA) -> E_Control=6'b000110, W=2, Mem=0; dout=0xC0C0 (JMP R3) -> E_Control=6'b001100; dout=0x6283 (LDR) -> E_Control=6'b001000, W=1.
REQ-026 SHALL cover: capture 0x1283, then enable=0 for 3 cycles while dout=0xFFFF -> IR stays 0x1283, decode_valid=0 on each of those cycles.
REQ-027 SHALL cover: reset driven 0 between clock edges after capturing 0xA005 -> all outputs 0 before the next edge; after release, with enable=0, outputs stay 0.
REQ-028 SHALL cover: dout=0xF025 (TRAP) -> IR=0xF025, E_Control=0, W=0, Mem=0, decode_valid=1.

Source files
------------

// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers the fetched instruction and its PC+1, and
// derives the execute, memory and writeback control fields from the opcode.
module lc3_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic        Mem_Control,
    output logic [1:0]  W_Control,
    output logic        decode_valid
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    logic [3:0] opcode;
    logic       imm_mode;
    logic [1:0] alu_control_next;
    logic [1:0] pcselect1_next;
    logic       pcselect2_next;
    logic       op2select_next;
    logic       mem_control_next;
    logic [1:0] w_control_next;
    logic [5:0] e_control_next;

    assign opcode   = dout[15:12];
    assign imm_mode = dout[5];

    // Pure function of the incoming word; unsupported opcodes fall through
    // to all-zero controls.
    always_comb begin
        alu_control_next = 2'b00;
        pcselect1_next   = 2'b00;
        pcselect2_next   = 1'b0;
        op2select_next   = 1'b0;
        mem_control_next = 1'b0;
        w_control_next   = WB_ALU;
        case (opcode)
            OP_ADD: begin
                alu_control_next = 2'b00;
                op2select_next   = ~imm_mode;
            end
            OP_AND: begin
                alu_control_next = 2'b01;
                op2select_next   = ~imm_mode;
            end
            OP_NOT: begin
                alu_control_next = 2'b10;
                op2select_next   = 1'b1;
            end
            OP_BR, OP_ST: begin
                pcselect1_next = 2'b01;
                pcselect2_next = 1'b1;
            end
            OP_JMP: begin
                pcselect1_next = 2'b11;
            end
            OP_LD: begin
                pcselect1_next = 2'b01;
                pcselect2_next = 1'b1;
                w_control_next = WB_MEM;
            end
            OP_LDR: begin
                pcselect1_next = 2'b10;
                w_control_next = WB_MEM;
            end
            OP_LDI: begin
                pcselect1_next   = 2'b01;
                pcselect2_next   = 1'b1;
                w_control_next   = WB_MEM;
                mem_control_next = 1'b1;
            end
            OP_LEA: begin
                pcselect1_next = 2'b01;
                pcselect2_next = 1'b1;
                w_control_next = WB_PC;
            end
            OP_STR: begin
                pcselect1_next = 2'b10;
            end
            OP_STI: begin
                pcselect1_next   = 2'b01;
                pcselect2_next   = 1'b1;
                mem_control_next = 1'b1;
            end
            default: begin
                alu_control_next = 2'b00;
            end
        endcase
    end

    assign e_control_next = {alu_control_next, pcselect1_next, pcselect2_next, op2select_next};

    // Held fields only move on an enabled edge; decode_valid is a one-cycle
    // marker of a fresh capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            IR           <= 16'h0000;
            npc_out      <= 16'h0000;
            E_Control    <= 6'b000000;
            Mem_Control  <= 1'b0;
            W_Control    <= 2'b00;
            decode_valid <= 1'b0;
        end else begin
            decode_valid <= enable_decode;
            if (enable_decode) begin
                IR          <= dout;
                npc_out     <= npc_in;
                E_Control   <= e_control_next;
                Mem_Control <= mem_control_next;
                W_Control   <= w_control_next;
            end
        end
    end

endmodule

// File: tb/tb_lc3_decode.sv
// Directed bench for lc3_decode: hand-computed control words per opcode,
// hold behaviour with enable low, and asynchronous reset.
module tb_lc3_decode;

    logic        clock;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic        Mem_Control;
    logic [1:0]  W_Control;
    logic        decode_valid;

    int tests = 0;
    int fails = 0;

    lc3_decode dut (
        .clock        (clock),
        .reset        (reset),
        .enable_decode(enable_decode),
        .dout         (dout),
        .npc_in       (npc_in),
        .IR           (IR),
        .npc_out      (npc_out),
        .E_Control    (E_Control),
        .Mem_Control  (Mem_Control),
        .W_Control    (W_Control),
        .decode_valid (decode_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ir_e, input logic [15:0] npc_e,
                           input logic [5:0] e_e, input logic m_e, input logic [1:0] w_e,
                           input logic v_e);
        chk({tag, ".IR"},    IR,                    ir_e);
        chk({tag, ".npc"},   npc_out,               npc_e);
        chk({tag, ".E"},     {10'd0, E_Control},    {10'd0, e_e});
        chk({tag, ".Mem"},   {15'd0, Mem_Control},  {15'd0, m_e});
        chk({tag, ".W"},     {14'd0, W_Control},    {14'd0, w_e});
        chk({tag, ".valid"}, {15'd0, decode_valid}, {15'd0, v_e});
        $display("[TB] %s IR=%h npc=%h E=%b M=%b W=%0d V=%b", tag, IR, npc_out,
                 E_Control, Mem_Control, W_Control, decode_valid);
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1ns later.
    task automatic step(input logic en, input logic [15:0] d, input logic [15:0] npc);
        @(negedge clock);
        enable_decode = en;
        dout          = d;
        npc_in        = npc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        enable_decode = 1'b1;
        dout          = 16'h1283;
        npc_in        = 16'h3001;
        #1;
        chk_all("reset0", 16'h0, 16'h0, 6'b000000, 1'b0, 2'd0, 1'b0);
        @(posedge clock); #1;
        chk_all("reset_en_edge", 16'h0, 16'h0, 6'b000000, 1'b0, 2'd0, 1'b0);

        @(negedge clock);
        enable_decode = 1'b0;
        reset         = 1'b1;
        @(posedge clock); #1;
        chk_all("post_release", 16'h0, 16'h0, 6'b000000, 1'b0, 2'd0, 1'b0);

        step(1'b1, 16'h1283, 16'h3001);
        chk_all("add_reg", 16'h1283, 16'h3001, 6'b000001, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h12A5, 16'h3002);
        chk_all("add_imm", 16'h12A5, 16'h3002, 6'b000000, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'hA005, 16'h3003);
        chk_all("ldi", 16'hA005, 16'h3003, 6'b000110, 1'b1, 2'd1, 1'b1);
        step(1'b1, 16'hE00A, 16'h3004);
        chk_all("lea", 16'hE00A, 16'h3004, 6'b000110, 1'b0, 2'd2, 1'b1);
        step(1'b1, 16'hC0C0, 16'h3005);
        chk_all("jmp", 16'hC0C0, 16'h3005, 6'b001100, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h6283, 16'h3006);
        chk_all("ldr", 16'h6283, 16'h3006, 6'b001000, 1'b0, 2'd1, 1'b1);
        step(1'b1, 16'h5283, 16'h3007);
        chk_all("and_reg", 16'h5283, 16'h3007, 6'b010001, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h52A1, 16'h3008);
        chk_all("and_imm", 16'h52A1, 16'h3008, 6'b010000, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h927F, 16'h3009);
        chk_all("not", 16'h927F, 16'h3009, 6'b100001, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h0E05, 16'h300A);
        chk_all("br", 16'h0E05, 16'h300A, 6'b000110, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h2205, 16'h300B);
        chk_all("ld", 16'h2205, 16'h300B, 6'b000110, 1'b0, 2'd1, 1'b1);
        step(1'b1, 16'h3205, 16'h300C);
        chk_all("st", 16'h3205, 16'h300C, 6'b000110, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h7283, 16'h300D);
        chk_all("str", 16'h7283, 16'h300D, 6'b001000, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'hB005, 16'h300E);
        chk_all("sti", 16'hB005, 16'h300E, 6'b000110, 1'b1, 2'd0, 1'b1);
        step(1'b1, 16'hF025, 16'h300F);
        chk_all("trap", 16'hF025, 16'h300F, 6'b000000, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h4800, 16'h3010);
        chk_all("jsr", 16'h4800, 16'h3010, 6'b000000, 1'b0, 2'd0, 1'b1);

        step(1'b1, 16'h1283, 16'h3011);
        chk_all("hold_cap", 16'h1283, 16'h3011, 6'b000001, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'hFFFF, 16'hFFFF);
            chk_all($sformatf("hold%0d", i), 16'h1283, 16'h3011, 6'b000001, 1'b0, 2'd0, 1'b0);
        end

        step(1'b1, 16'hA005, 16'h4001);
        chk_all("pre_rst", 16'hA005, 16'h4001, 6'b000110, 1'b1, 2'd1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 16'h0, 16'h0, 6'b000000, 1'b0, 2'd0, 1'b0);
        enable_decode = 1'b1;
        @(posedge clock); #1;
        chk_all("rst_hold_edge", 16'h0, 16'h0, 6'b000000, 1'b0, 2'd0, 1'b0);
        @(negedge clock);
        enable_decode = 1'b0;
        reset         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'hA005, 16'h4001);
            chk_all($sformatf("rel_idle%0d", i), 16'h0, 16'h0, 6'b000000, 1'b0, 2'd0, 1'b0);
        end
        step(1'b1, 16'h12A5, 16'h5000);
        chk_all("rel_cap", 16'h12A5, 16'h5000, 6'b000000, 1'b0, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
